// File: rtl/fft_frame_sink.sv
// Two-bank frame buffer behind the FFT output: captures sync-marked frames at the
// FFT's fixed rate and replays complete frames over a back-pressured valid/ready stream.
module fft_frame_sink #(
   parameter int OWIDTH  = 20,
   parameter int LGWIDTH = 7
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_ce,
   input  logic                  i_sync,
   input  logic [2*OWIDTH-1:0]   i_result,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [2*OWIDTH-1:0]   o_data,
   output logic [LGWIDTH-1:0]    o_index,
   output logic                  o_last,
   output logic [7:0]            o_dropped,
   output logic                  o_syncerr
);

   localparam int W = 2*OWIDTH;
   localparam int N = 1 << LGWIDTH;
   localparam logic [LGWIDTH-1:0] LAST_IDX = LGWIDTH'(N-1);

   typedef enum logic [1:0] {WR_HUNT, WR_FILL, WR_DISCARD} wr_state_t;
   typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

   // Handshake: a word transfers on a rising edge where o_valid && i_ready; while
   // o_valid is high and i_ready low, o_valid/o_data/o_index/o_last hold their values.

   logic [W-1:0]       mem [2*N];
   logic [1:0]         full;

   wr_state_t          wr_state;
   logic [LGWIDTH-1:0] wr_idx;
   logic               wr_bank;

   rd_state_t          rd_state;
   logic [LGWIDTH-1:0] rd_idx;
   logic               rd_bank;
   logic               s1_valid;
   logic [LGWIDTH-1:0] s1_idx;
   logic [W-1:0]       s1_data;

   logic               wr_active;
   logic               wr_we;
   logic               wr_end_fill;
   logic [LGWIDTH:0]   wr_addr;
   logic               out_load;
   logic               s1_free;
   logic               rd_fetch;
   logic               rd_end;
   logic [1:0]         full_set;
   logic [1:0]         full_clr;

   assign wr_active   = (wr_state != WR_HUNT);
   assign wr_we       = i_ce && (i_sync ? !full[wr_bank] : (wr_state == WR_FILL));
   assign wr_addr     = {wr_bank, (i_sync ? {LGWIDTH{1'b0}} : wr_idx)};
   assign wr_end_fill = i_ce && !i_sync && (wr_state == WR_FILL) && (wr_idx == LAST_IDX);

   // Two-stage read: RAM output register (s1) feeding the output register.
   assign out_load = s1_valid && (!o_valid || i_ready);
   assign s1_free  = !s1_valid || out_load;
   assign rd_fetch = s1_free && ((rd_state == RD_STREAM) || full[rd_bank]);
   assign rd_end   = rd_fetch && (rd_idx == LAST_IDX);

   // A bank is released once its last word has left the RAM; the remaining words
   // live in the output pipeline, so the writer can reuse the bank without a gap.
   assign full_set = wr_end_fill ? (2'b01 << wr_bank) : 2'b00;
   assign full_clr = rd_end      ? (2'b01 << rd_bank) : 2'b00;

   always_ff @(posedge i_clk) begin
      if (wr_we)
         mem[wr_addr] <= i_result;
      if (rd_fetch)
         s1_data <= mem[{rd_bank, rd_idx}];
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         full <= 2'b00;
      else
         full <= (full & ~full_clr) | full_set;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_state  <= WR_HUNT;
         wr_idx    <= '0;
         wr_bank   <= 1'b0;
         o_dropped <= 8'd0;
         o_syncerr <= 1'b0;
      end else if (i_ce) begin
         if (i_sync) begin
            // Any sync starts a new frame; one inside a frame abandons the partial frame.
            if (wr_active)
               o_syncerr <= 1'b1;
            wr_idx <= LGWIDTH'(1);
            if (full[wr_bank]) begin
               wr_state <= WR_DISCARD;
               if (o_dropped != 8'hff)
                  o_dropped <= o_dropped + 8'd1;
            end else begin
               wr_state <= WR_FILL;
            end
         end else if (wr_active) begin
            if (wr_idx == LAST_IDX) begin
               wr_state <= WR_HUNT;
               wr_idx   <= '0;
               if (wr_state == WR_FILL)
                  wr_bank <= ~wr_bank;
            end else begin
               wr_idx <= wr_idx + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rd_state <= RD_IDLE;
         rd_idx   <= '0;
         rd_bank  <= 1'b0;
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         o_valid  <= 1'b0;
         o_data   <= '0;
         o_index  <= '0;
         o_last   <= 1'b0;
      end else begin
         if (rd_fetch) begin
            s1_valid <= 1'b1;
            s1_idx   <= rd_idx;
            if (rd_idx == LAST_IDX) begin
               rd_idx   <= '0;
               rd_bank  <= ~rd_bank;
               rd_state <= full[~rd_bank] ? RD_STREAM : RD_IDLE;
            end else begin
               rd_idx   <= rd_idx + 1'b1;
               rd_state <= RD_STREAM;
            end
         end else if (out_load) begin
            s1_valid <= 1'b0;
         end

         if (out_load) begin
            o_valid <= 1'b1;
            o_data  <= s1_data;
            o_index <= s1_idx;
            o_last  <= (s1_idx == LAST_IDX);
         end else if (i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_sink.sv
// Bench for fft_frame_sink: random frames through a frame-parsing reference model,
// with an expected-word queue checked at every output handshake.
module tb_fft_frame_sink;

   localparam int OWIDTH  = 20;
   localparam int LGWIDTH = 7;
   localparam int W       = 2*OWIDTH;
   localparam int N       = 1 << LGWIDTH;
   localparam int EW      = 1 + LGWIDTH + W;

   logic               i_clk;
   logic               i_reset;
   logic               i_ce;
   logic               i_sync;
   logic [W-1:0]       i_result;
   logic               o_valid;
   logic               i_ready;
   logic [W-1:0]       o_data;
   logic [LGWIDTH-1:0] o_index;
   logic               o_last;
   logic [7:0]         o_dropped;
   logic               o_syncerr;

   fft_frame_sink #(.OWIDTH(OWIDTH), .LGWIDTH(LGWIDTH)) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_ce      (i_ce),
      .i_sync    (i_sync),
      .i_result  (i_result),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_data    (o_data),
      .o_index   (o_index),
      .o_last    (o_last),
      .o_dropped (o_dropped),
      .o_syncerr (o_syncerr)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_exp, n_seen, exp_drops;
   int test_id, ready_mode;
   int first_valid_cyc, last_smp_cyc;
   bit exp_syncerr;

   logic          st_sync[$];
   logic [W-1:0]  st_data[$];
   logic [EW-1:0] exp_q[$];

   // clock / reset
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      #2 i_reset = 1'b1;
      #1;
      check("rst_out", 64'({o_valid, o_last, o_index, o_data, o_dropped, o_syncerr}), 64'd0);
      repeat (3) @(posedge i_clk);
      exp_q.delete();
      n_exp = 0;
      n_seen = 0;
      exp_drops = 0;
      exp_syncerr = 1'b0;
      first_valid_cyc = -1;
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   // driver tasks
   task automatic add_samples(input int count, input bit first_sync, input bit rand_data);
      for (int k = 0; k < count; k++) begin
         logic [63:0] r;
         r = {$urandom(), $urandom()};
         st_sync.push_back(first_sync && (k == 0));
         st_data.push_back(rand_data ? r[W-1:0] : W'(k));
      end
   endtask

   task automatic drive(input int gap);
      for (int k = 0; k < st_sync.size(); k++) begin
         @(posedge i_clk);
         #1;
         i_ce = 1'b1;
         i_sync = st_sync[k];
         i_result = st_data[k];
         last_smp_cyc = cyc;
         for (int g = 0; g < gap; g++) begin
            @(posedge i_clk);
            #1;
            i_ce = 1'b0;
            i_sync = 1'($urandom_range(0, 1));
            i_result = W'($urandom());
         end
      end
      @(posedge i_clk);
      #1;
      i_ce = 1'b0;
      i_sync = 1'b0;
      st_sync.delete();
      st_data.delete();
   endtask

   initial forever begin
      @(posedge i_clk);
      #1;
      case (ready_mode)
         0:       i_ready = 1'b0;
         1:       i_ready = 1'b1;
         default: i_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Reference model: split the sample list into frames (sync followed by N-1
   // sync-free samples); a sync arriving early restarts the frame and flags an error.
   task automatic model_parse(input int drop_mask);
      int i, j, nf;
      int n;
      n = st_sync.size();
      i = 0;
      nf = 0;
      while (i < n) begin
         if (!st_sync[i]) begin
            i++;
         end else begin
            j = 1;
            while (j < N && i + j < n && !st_sync[i + j]) j++;
            if (j == N) begin
               if (drop_mask[nf]) begin
                  exp_drops++;
               end else begin
                  for (int k = 0; k < N; k++) begin
                     exp_q.push_back({(k == N-1), LGWIDTH'(k), st_data[i + k]});
                     n_exp++;
                  end
               end
               nf++;
               i += N;
            end else if (i + j < n) begin
               exp_syncerr = 1'b1;
               i += j;
            end else begin
               i = n;
            end
         end
      end
   endtask

   // scoreboard / monitor, sampled on the falling edge
   logic [EW-1:0] prev_word;
   bit prev_stall = 1'b0;
   bit prev_valid = 1'b0;
   bit after_last = 1'b0;
   int gap = 0;

   initial forever begin
      @(negedge i_clk);
      if (i_reset) begin
         prev_stall = 1'b0;
         prev_valid = 1'b0;
         after_last = 1'b0;
      end else begin
         if (prev_stall)
            check("hold", 64'({o_valid, o_last, o_index, o_data}), 64'({1'b1, prev_word}));
         if (o_valid && !prev_valid && first_valid_cyc < 0)
            first_valid_cyc = cyc;
         if (after_last) begin
            if (o_valid) begin
               if (test_id == 2)
                  check("frame_gap", 64'((gap <= 1) ? 0 : gap), 64'd0);
               after_last = 1'b0;
            end else begin
               gap++;
            end
         end
         if (o_valid && i_ready) begin
            n_seen++;
            if (exp_q.size() > 0)
               check("word", 64'({o_last, o_index, o_data}), 64'(exp_q.pop_front()));
            if (o_last) begin
               after_last = 1'b1;
               gap = 0;
            end
         end
         prev_stall = o_valid && !i_ready;
         prev_word  = {o_last, o_index, o_data};
         prev_valid = o_valid;
      end
   end

   task automatic finish_test(input string name);
      int t;
      t = 0;
      while (n_seen < n_exp && t < 4000) begin
         @(negedge i_clk);
         t++;
      end
      repeat (300) @(negedge i_clk);
      check($sformatf("%s_count", name), 64'(n_seen), 64'(n_exp));
      check($sformatf("%s_dropped", name), 64'(o_dropped), 64'(exp_drops));
      check($sformatf("%s_syncerr", name), 64'(o_syncerr), 64'(exp_syncerr));
   endtask

   initial begin
      int t;
      i_reset = 1'b0;
      i_ce = 1'b0;
      i_sync = 1'b0;
      i_result = '0;
      i_ready = 1'b1;
      ready_mode = 1;
      test_id = 0;
      first_valid_cyc = -1;
      last_smp_cyc = 0;
      repeat (2) @(posedge i_clk);

      // single frame, data = index, measure capture-to-output latency
      test_id = 1;
      do_reset();
      add_samples(N, 1'b1, 1'b0);
      model_parse(0);
      drive(0);
      finish_test("t1");
      check("t1_latency", 64'(first_valid_cyc - last_smp_cyc), 64'd3);

      // four continuous frames
      test_id = 2;
      do_reset();
      for (int f = 0; f < 4; f++) add_samples(N, 1'b1, 1'b1);
      model_parse(0);
      drive(0);
      finish_test("t2");

      // downstream stalled for three frames: third one is dropped
      test_id = 3;
      do_reset();
      ready_mode = 0;
      for (int f = 0; f < 3; f++) add_samples(N, 1'b1, 1'b1);
      model_parse(32'h4);
      drive(0);
      ready_mode = 1;
      finish_test("t3");

      // random ready, sample every other cycle
      test_id = 4;
      do_reset();
      ready_mode = 2;
      for (int f = 0; f < 3; f++) add_samples(N, 1'b1, 1'b1);
      model_parse(0);
      drive(1);
      finish_test("t4");
      ready_mode = 1;

      // sync at write index 40
      test_id = 5;
      do_reset();
      add_samples(40, 1'b1, 1'b1);
      add_samples(N, 1'b1, 1'b1);
      model_parse(0);
      drive(0);
      finish_test("t5");

      // reset in the middle of streaming, then hunt for a fresh sync
      test_id = 6;
      do_reset();
      add_samples(N, 1'b1, 1'b1);
      model_parse(0);
      drive(0);
      t = 0;
      while (n_seen < 50 && t < 1000) begin
         @(negedge i_clk);
         t++;
      end
      check("t6_midstream", 64'((n_seen >= 50) ? 1 : 0), 64'd1);
      do_reset();
      add_samples(200, 1'b0, 1'b1);
      add_samples(N, 1'b1, 1'b1);
      model_parse(0);
      drive(0);
      finish_test("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
